// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries feeding decode.
// Flush has priority over push and pop; a pop on an empty queue is ignored.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  fetch_entry_t              push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count,
  output fetch_entry_t              head
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QDEPTH);

  fetch_entry_t mem [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;

  assign do_pop = pop && (cnt != '0);
  assign full   = (cnt == DEPTH_C);
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign head   = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Credit accounting upstream must never let a response land in a full queue.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one word read at a
// time over req/gnt/rvalid, queues responses toward decode and discards
// responses made stale by a redirect.
//
// state | meaning
// IDLE  | no request; waits for queue credit
// REQ   | imem_req high, address held until imem_gnt
// WAIT  | granted, waiting for imem_rvalid
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_src,
  input  logic [31:0] target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QDEPTH);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc, fetch_pc_next;
  logic [XLEN-1:0] addr_q;
  logic            stale, stale_next;
  logic [AW:0]     q_count, count_next;
  logic            q_full, q_empty;
  logic            push, pop, resp_done, credit;
  fetch_entry_t    push_data, head;
  logic            unused_bits;

  // addr_q doubles as the PC of the outstanding request, so it is what gets queued.
  assign push_data   = '{pc: addr_q, instr: imem_rdata};
  assign imem_req    = (state == REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = !q_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign unused_bits = ^{target_pc[1:0], q_full};

  // Next state, PC, stale flag and credit; a redirect overrides everything else.
  always_comb begin
    state_next    = state;
    stale_next    = stale;
    fetch_pc_next = fetch_pc;
    resp_done     = (state == WAIT) && imem_rvalid;
    push          = resp_done && !stale && !pc_src;
    pop           = !q_empty && instr_ready && !pc_src;
    if (pc_src) count_next = '0;
    else        count_next = q_count + (AW+1)'(push) - (AW+1)'(pop);
    credit        = (count_next < DEPTH_C);

    case (state)
      IDLE: if (credit) state_next = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_next = WAIT;
          // A stale grant belongs to the old stream; fetch_pc already holds the target.
          if (!stale) fetch_pc_next = fetch_pc + PC_STEP;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_next = credit ? REQ : IDLE;
          stale_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (pc_src) begin
      fetch_pc_next = {target_pc[XLEN-1:2], 2'b00};
      // A response completing this same cycle is dropped here, so nothing is left to mark.
      if (state != IDLE && !resp_done) stale_next = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // PC, stale flag and request address; the address only moves when a new request starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      stale    <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next;
      stale    <= stale_next;
      if (state_next == REQ && state != REQ) addr_q <= fetch_pc_next;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (pc_src),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .head      (head)
  );

endmodule
